// File: rtl/calc_pkg.sv
// Shared constants, FSM encoding and helpers for the slice-serial subtractor.
package calc_pkg;

  localparam int DATA_W  = 32;
  localparam int SLICE_W = 8;
  localparam int NSLICES = DATA_W / SLICE_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CALC   = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              bout;
  } calc_rsp_t;

  // Magnitude of a negative result: bitwise invert plus one.
  function automatic logic [DATA_W-1:0] twos_neg(input logic [DATA_W-1:0] v);
    return (~v) + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/sub_slice.sv
// Combinational SLICE_W-bit subtract with borrow in/out.
module sub_slice #(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               bi_i,
  output logic [SLICE_W-1:0] diff_o,
  output logic               bo_o
);

  logic [SLICE_W:0] full;

  // A negative result sets the extra top bit, which is exactly the borrow.
  assign full   = {1'b0, a_i} - {1'b0, b_i} - {{SLICE_W{1'b0}}, bi_i};
  assign diff_o = full[SLICE_W-1:0];
  assign bo_o   = full[SLICE_W];

endmodule

// File: rtl/calculation_sub.sv
// Slice-serial 32-bit subtractor with optional magnitude; one slice per cycle,
// fixed 5-cycle latency from accepted start to done.
module calculation_sub
  import calc_pkg::*;
#(
  parameter int SLICE_W = calc_pkg::SLICE_W
) (
  input  logic              sub_clk,
  input  logic              sub_rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              bin,
  input  logic              abs_en,
  output logic [DATA_W-1:0] d,
  output logic              bout,
  output logic              busy,
  output logic              done
);

  localparam int NS = DATA_W / SLICE_W;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NS - 1);

  logic [1:0]                  state_q, state_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic                        borrow_q, borrow_d;
  logic                        abs_q, abs_d;
  logic [NS-1:0][SLICE_W-1:0]  a_q, a_d;
  logic [NS-1:0][SLICE_W-1:0]  b_q, b_d;
  logic [NS-1:0][SLICE_W-1:0]  diff_q, diff_d;
  calc_rsp_t                   rsp_q, rsp_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic [SLICE_W-1:0] sl_diff;
  logic               sl_bo;

  // One slice subtractor, fed from the operand slice selected by idx_q.
  sub_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a_i    (a_q[idx_q]),
    .b_i    (b_q[idx_q]),
    .bi_i   (borrow_q),
    .diff_o (sl_diff),
    .bo_o   (sl_bo)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    abs_d    = abs_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    rsp_d    = rsp_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          abs_d    = abs_en;
          idx_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        diff_d[idx_q] = sl_diff;
        borrow_d      = sl_bo;
        // Index parks on the last slice; FINISH is what brings it back to 0.
        if (idx_q == LAST_IDX) state_d = ST_FINISH;
        else                   idx_d   = idx_q + 1'b1;
      end
      ST_FINISH: begin
        rsp_d.bout = borrow_q;
        rsp_d.d    = (abs_q && borrow_q) ? twos_neg(diff_q) : diff_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        idx_d      = '0;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sub_clk) begin
    if (sub_rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      abs_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      rsp_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      abs_q    <= abs_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      rsp_q    <= rsp_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign d    = rsp_q.d;
  assign bout = rsp_q.bout;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_calculation_sub.sv
// Randomized bench for calculation_sub against an arithmetic reference model.
module tb_calculation_sub;

  logic        sub_clk = 1'b0;
  logic        sub_rst = 1'b1;
  logic        start   = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        bin = 1'b0, abs_en = 1'b0;
  logic [31:0] d;
  logic        bout, busy, done;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] last_d;
  logic        last_bout;

  calculation_sub #(.SLICE_W(8)) dut (
    .sub_clk (sub_clk),
    .sub_rst (sub_rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .bin     (bin),
    .abs_en  (abs_en),
    .d       (d),
    .bout    (bout),
    .busy    (busy),
    .done    (done)
  );

  always #5 sub_clk = ~sub_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h exp %08h", tag, got, exp);
    end
  endtask

  // {bout, d}: bout when a < b+bin; d is the wrapped difference or its magnitude.
  function automatic logic [32:0] ref_sub(input logic [31:0] av, input logic [31:0] bv,
                                          input logic bi, input logic ab);
    longint unsigned sa, sb, mag, t;
    sa = longint'(av);
    sb = longint'(bv) + longint'(bi);
    if (sa >= sb) begin
      t = sa - sb;
      return {1'b0, t[31:0]};
    end
    mag = sb - sa;
    t   = ab ? mag : (64'h1_0000_0000 - mag);
    return {1'b1, t[31:0]};
  endfunction

  task automatic scramble_inputs();
    a      = $urandom;
    b      = $urandom;
    bin    = 1'($urandom_range(0, 1));
    abs_en = 1'($urandom_range(0, 1));
  endtask

  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        input logic bi, input logic ab, input string tag);
    logic [32:0] exp;
    int          lat;
    exp = ref_sub(av, bv, bi, ab);
    @(negedge sub_clk);
    a = av; b = bv; bin = bi; abs_en = ab; start = 1'b1;
    @(posedge sub_clk); #1;
    start = 1'b0;
    scramble_inputs();
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(posedge sub_clk); #1;
      if (done) lat = i;
    end
    chk({tag, "_lat"},  lat,        32'd5);
    chk({tag, "_d"},    d,          exp[31:0]);
    chk({tag, "_bout"}, 32'(bout),  32'(exp[32]));
    @(posedge sub_clk); #1;
    chk({tag, "_pulse"}, 32'(done), 32'd0);
    chk({tag, "_hold"},  d,         exp[31:0]);
    last_d    = exp[31:0];
    last_bout = exp[32];
  endtask

  initial begin
    logic [32:0] exp;
    int          ndone, lat;
    logic [31:0] got_d;
    logic        got_b;
    logic [31:0] ha [3];
    logic [31:0] hb [3];
    logic        hbi[3];
    logic        hab[3];

    repeat (2) @(posedge sub_clk);
    #1;
    chk("rst_d",    d,          32'd0);
    chk("rst_bout", 32'(bout),  32'd0);
    chk("rst_busy", 32'(busy),  32'd0);
    chk("rst_done", 32'(done),  32'd0);
    sub_rst = 1'b0;

    run_op(32'd50,         32'd13,  1'b0, 1'b0, "basic");
    run_op(32'd105,        32'd256, 1'b0, 1'b0, "neg");
    run_op(32'd105,        32'd256, 1'b0, 1'b1, "neg_abs");
    run_op(32'd0,          32'd0,   1'b1, 1'b1, "zero_bin_abs");
    run_op(32'd0,          32'd0,   1'b1, 1'b0, "zero_bin");
    run_op(32'hFFFF_FFFF,  32'd0,   1'b0, 1'b0, "max");
    run_op(32'h1234_5678,  32'h1234_5678, 1'b0, 1'b1, "equal");
    run_op(32'h0001_0000,  32'h0000_00FF, 1'b1, 1'b0, "borrow_chain");

    // Start re-pulsed mid-operation with different operands must be ignored.
    exp = ref_sub(32'd1000, 32'd1, 1'b0, 1'b0);
    @(negedge sub_clk);
    a = 32'd1000; b = 32'd1; bin = 1'b0; abs_en = 1'b0; start = 1'b1;
    @(posedge sub_clk); #1;
    start = 1'b0;
    @(posedge sub_clk); #1;
    a = 32'd7; b = 32'd9; bin = 1'b1; abs_en = 1'b1; start = 1'b1;
    @(posedge sub_clk); #1;
    start = 1'b0;
    ndone = 0; lat = 0; got_d = '0; got_b = 1'b0;
    for (int i = 3; i <= 12; i++) begin
      @(posedge sub_clk); #1;
      if (done) begin
        ndone++;
        if (lat == 0) begin lat = i; got_d = d; got_b = bout; end
      end
    end
    chk("repulse_ndone", ndone,      32'd1);
    chk("repulse_lat",   lat,        32'd5);
    chk("repulse_d",     got_d,      exp[31:0]);
    chk("repulse_bout",  32'(got_b), 32'(exp[32]));

    // Reset in the middle of CALC aborts without a done pulse.
    @(negedge sub_clk);
    a = 32'd77; b = 32'd5; bin = 1'b0; abs_en = 1'b0; start = 1'b1;
    @(posedge sub_clk); #1;
    start = 1'b0;
    @(posedge sub_clk);
    @(posedge sub_clk); #1;
    sub_rst = 1'b1;
    @(posedge sub_clk); #1;
    sub_rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_d",    d,         32'd0);
    chk("abort_bout", 32'(bout), 32'd0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) ndone++;
      @(posedge sub_clk); #1;
    end
    chk("abort_ndone", ndone, 32'd0);
    run_op(32'd77, 32'd5, 1'b0, 1'b0, "after_abort");

    // Start held high: each op accepted the cycle after the previous done.
    ha[0] = 32'd500;        hb[0] = 32'd499;        hbi[0] = 1'b0; hab[0] = 1'b0;
    ha[1] = 32'd3;          hb[1] = 32'd10;         hbi[1] = 1'b1; hab[1] = 1'b1;
    ha[2] = 32'hDEAD_BEEF;  hb[2] = 32'hFFFF_0000;  hbi[2] = 1'b0; hab[2] = 1'b0;
    @(negedge sub_clk);
    a = ha[0]; b = hb[0]; bin = hbi[0]; abs_en = hab[0]; start = 1'b1;
    for (int j = 0; j < 3; j++) begin
      exp = ref_sub(ha[j], hb[j], hbi[j], hab[j]);
      lat = 0;
      for (int i = 1; i <= 12 && lat == 0; i++) begin
        @(posedge sub_clk); #1;
        if (done) lat = i;
        else if (i == 3) chk($sformatf("held%0d_hold", j), d, last_d);
      end
      chk($sformatf("held%0d_gap", j),  lat,       32'd6);
      chk($sformatf("held%0d_d", j),    d,         exp[31:0]);
      chk($sformatf("held%0d_bout", j), 32'(bout), 32'(exp[32]));
      last_d    = exp[31:0];
      last_bout = exp[32];
      if (j < 2) begin
        a = ha[j+1]; b = hb[j+1]; bin = hbi[j+1]; abs_en = hab[j+1];
      end else begin
        start = 1'b0;
      end
    end
    @(posedge sub_clk); #1;
    chk("held_end_done", 32'(done), 32'd0);
    @(posedge sub_clk); #1;
    chk("held_end_busy", 32'(busy), 32'd0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      case (n % 5)
        0: rb = ra;
        1: ra = ra >> $urandom_range(0, 31);
        2: rb = rb >> $urandom_range(0, 31);
        default: ;
      endcase
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
